// File: rtl/game_round_ctrl_pkg.sv
// Shared types and widths for the mental-math round sequencer.
package game_pkg;

  localparam int SUM_W = 5;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RELOAD,
    ARM,
    GEN,
    CHECK,
    DONE
  } game_state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player/datapath bundle: master drives the game inputs, slave is the round controller.
interface game_round_ctrl_if;
  import game_pkg::*;

  logic             logged_in;
  logic             p1_load;
  logic [CNT_W-1:0] p1_value;
  logic [CNT_W-1:0] rng_value;
  logic             timer_done;

  logic             load_p1;
  logic             rng_gen;
  logic             timer_reconfig;
  logic             timer_enable;
  logic [CNT_W-1:0] round;
  logic [CNT_W-1:0] score;
  logic             match;
  logic             miss;
  logic             game_over;
  logic [CNT_W-1:0] streak;

  modport master (
    output logged_in, p1_load, p1_value, rng_value, timer_done,
    input  load_p1, rng_gen, timer_reconfig, timer_enable,
    input  round, score, match, miss, game_over, streak
  );

  modport slave (
    input  logged_in, p1_load, p1_value, rng_value, timer_done,
    output load_p1, rng_gen, timer_reconfig, timer_enable,
    output round, score, match, miss, game_over, streak
  );

endinterface

// File: rtl/game_round_ctrl_score_counter.sv
// Round/score/streak counters; all registered, cleared by reset or i_clr.
// GAME_STREAK_EN: streak tracking and the +2 bonus for matches on a streak of 2 or more.
module game_score_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_round_inc,
  input  logic             i_score_inc,
  input  logic             i_streak_clr,
  output logic [CNT_W-1:0] o_round,
  output logic [CNT_W-1:0] o_score,
  output logic [CNT_W-1:0] o_streak
);

  logic [CNT_W-1:0] r_round;
  logic [CNT_W-1:0] r_score;
  logic [CNT_W-1:0] w_step;

`ifdef GAME_STREAK_EN
  logic [CNT_W-1:0] r_streak;

  assign w_step = (r_streak >= CNT_W'(2)) ? CNT_W'(2) : CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_streak <= '0;
    end else if (i_score_inc) begin
      r_streak <= sat_add(r_streak, CNT_W'(1));
    end else if (i_streak_clr) begin
      r_streak <= '0;
    end
  end

  assign o_streak = r_streak;
`else
  logic w_unused_streak_clr;

  assign w_step              = CNT_W'(1);
  assign w_unused_streak_clr = i_streak_clr;
  assign o_streak            = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_round <= '0;
      r_score <= '0;
    end else begin
      if (i_round_inc) begin
        r_round <= r_round + CNT_W'(1);
      end
      if (i_score_inc) begin
        r_score <= sat_add(r_score, w_step);
      end
    end
  end

  assign o_round = r_round;
  assign o_score = r_score;

endmodule

// File: rtl/game_round_ctrl.sv
// Multi-round game sequencer: arms the digit timer, strobes load/RNG on commit, scores sum vs TARGET.
// Outputs all registered; commit result visible 3 cycles after p1_load. GAME_STREAK_EN enables streak bonus.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUNDS = 5,
  parameter int TARGET = 15
) (
  input  logic              clk,
  input  logic              rst,
  game_round_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS);
  localparam logic [SUM_W-1:0] TARGET_SUM = SUM_W'(TARGET);

  game_state_t      r_state;
  logic [CNT_W-1:0] r_p1;
  logic             r_load_p1;
  logic             r_rng_gen;
  logic             r_timer_reconfig;
  logic             r_timer_enable;
  logic             r_match;
  logic             r_miss;
  logic             r_game_over;

  logic [SUM_W-1:0] w_sum;
  logic             w_hit;
  logic             w_timeout;
  logic             w_advance;
  logic             w_last;
  logic             w_clr;
  logic             w_round_inc;
  logic             w_score_inc;
  logic             w_streak_clr;
  logic [CNT_W-1:0] w_round;
  logic [CNT_W-1:0] w_score;
  logic [CNT_W-1:0] w_streak;

  assign w_sum        = {1'b0, r_p1} + {1'b0, bus.rng_value};
  assign w_hit        = (w_sum == TARGET_SUM);
  // A commit in the same cycle as timer expiry wins over the timeout.
  assign w_timeout    = (r_state == ARM) && !bus.p1_load && bus.timer_done;
  assign w_advance    = w_timeout || (r_state == CHECK);
  assign w_last       = (w_round == LAST_ROUND);
  assign w_clr        = !bus.logged_in;
  assign w_round_inc  = bus.logged_in && ((r_state == IDLE) || (w_advance && !w_last));
  assign w_score_inc  = bus.logged_in && (r_state == CHECK) && w_hit;
  assign w_streak_clr = bus.logged_in && w_advance && !w_score_inc;

  game_score_counter u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_round_inc  (w_round_inc),
    .i_score_inc  (w_score_inc),
    .i_streak_clr (w_streak_clr),
    .o_round      (w_round),
    .o_score      (w_score),
    .o_streak     (w_streak)
  );

  always_ff @(posedge clk) begin
    if (!rst || !bus.logged_in) begin
      r_state          <= IDLE;
      r_p1             <= '0;
      r_load_p1        <= 1'b0;
      r_rng_gen        <= 1'b0;
      r_timer_reconfig <= 1'b0;
      r_timer_enable   <= 1'b0;
      r_match          <= 1'b0;
      r_miss           <= 1'b0;
      r_game_over      <= 1'b0;
    end else begin
      r_load_p1        <= 1'b0;
      r_rng_gen        <= 1'b0;
      r_timer_reconfig <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state          <= RELOAD;
          r_timer_reconfig <= 1'b1;
        end
        RELOAD: begin
          r_state        <= ARM;
          r_timer_enable <= 1'b1;
        end
        ARM: begin
          if (bus.p1_load) begin
            r_p1           <= bus.p1_value;
            r_load_p1      <= 1'b1;
            r_rng_gen      <= 1'b1;
            r_timer_enable <= 1'b0;
            r_state        <= GEN;
          end else if (bus.timer_done) begin
            r_match <= 1'b0;
            r_miss  <= 1'b1;
          end
        end
        GEN:   r_state <= CHECK;
        CHECK: begin
          r_match <= w_hit;
          r_miss  <= !w_hit;
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
      if (w_advance) begin
        r_timer_enable <= 1'b0;
        if (w_last) begin
          r_state     <= DONE;
          r_game_over <= 1'b1;
        end else begin
          r_state          <= RELOAD;
          r_timer_reconfig <= 1'b1;
        end
      end
    end
  end

  assign bus.load_p1        = r_load_p1;
  assign bus.rng_gen        = r_rng_gen;
  assign bus.timer_reconfig = r_timer_reconfig;
  assign bus.timer_enable   = r_timer_enable;
  assign bus.round          = w_round;
  assign bus.score          = w_score;
  assign bus.streak         = w_streak;
  assign bus.match          = r_match;
  assign bus.miss           = r_miss;
  assign bus.game_over      = r_game_over;

endmodule
